// File: rtl/m1auth_seq.sv
// m1auth_seq: sequences a Crypto1 core through the reader side of a MIFARE
// Classic three-pass authentication (key load, uid^nt init, nr, ar keystream).
// The core's tx output is registered, so each tx bit is captured one cycle
// after its start pulse.
// Optional build macro M1AUTH_KS_STREAM_EN adds a keystream byte stream
// after the result has been accepted.
module m1auth_seq #(
  parameter int WORD_W = 32,
  parameter int KEY_W  = 48
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic [WORD_W-1:0] cmd_uidnt,
  input  logic [WORD_W-1:0] cmd_nr,
  input  logic              abort,
  output logic [KEY_W-1:0]  c1_key,
  output logic              c1_load_key,
  output logic              c1_start,
  output logic              c1_ser_in,
  input  logic              c1_tx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_enc_nr,
  output logic [WORD_W-1:0] res_ks_ar,
  output logic              busy
`ifdef M1AUTH_KS_STREAM_EN
  ,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [7:0]        ks_byte,
  input  logic              stream_stop
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT, S_NR, S_AR, S_FLUSH, S_DONE
`ifdef M1AUTH_KS_STREAM_EN
    , S_STREAM, S_KS_FLUSH, S_KS_OUT
`endif
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [6:0]         r_cnt;
  logic [KEY_W-1:0]   r_key;
  logic [WORD_W-1:0]  r_uidnt;
  logic [WORD_W-1:0]  r_nr;
  logic [WORD_W-1:0]  r_ks_nr;
  logic [WORD_W-1:0]  r_ks_ar;
  logic               r_cap_nr;
  logic               r_cap_ar;
  logic               w_last;
  logic               w_accept;
  logic               w_res_valid;
`ifdef M1AUTH_KS_STREAM_EN
  logic [7:0]         r_ks_byte;
  logic               r_cap_ks;
  logic               w_ks_valid;
  logic               w_streaming;
`endif

  assign w_last   = (r_cnt == 7'd31);
  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  // State register, bit counter, command capture and tx capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_key    <= '0;
      r_uidnt  <= '0;
      r_nr     <= '0;
      r_ks_nr  <= '0;
      r_ks_ar  <= '0;
      r_cap_nr <= 1'b0;
      r_cap_ar <= 1'b0;
`ifdef M1AUTH_KS_STREAM_EN
      r_ks_byte <= '0;
      r_cap_ks  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_key   <= cmd_key;
        r_uidnt <= cmd_uidnt;
        r_nr    <= cmd_nr;
      end
      // One counter serves every phase; it wraps when the phase changes.
      if (r_state == S_INIT || r_state == S_NR || r_state == S_AR)
        r_cnt <= w_last ? 7'd0 : 7'(r_cnt + 7'd1);
`ifdef M1AUTH_KS_STREAM_EN
      else if (r_state == S_STREAM)
        r_cnt <= (r_cnt == 7'd7) ? 7'd0 : 7'(r_cnt + 7'd1);
`endif
      else
        r_cnt <= '0;
      // tx seen this cycle belongs to the start pulse of the previous cycle.
      r_cap_nr <= (r_state == S_NR);
      r_cap_ar <= (r_state == S_AR);
      if (r_cap_nr) r_ks_nr <= {c1_tx, r_ks_nr[WORD_W-1:1]};
      if (r_cap_ar) r_ks_ar <= {c1_tx, r_ks_ar[WORD_W-1:1]};
`ifdef M1AUTH_KS_STREAM_EN
      r_cap_ks <= (r_state == S_STREAM);
      if (r_cap_ks) r_ks_byte <= {c1_tx, r_ks_byte[7:1]};
`endif
    end
  end

  // Next-state and cipher control decode.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next      = r_state;
    c1_load_key = 1'b0;
    c1_start    = 1'b0;
    c1_ser_in   = 1'b0;
    cmd_ready   = 1'b0;
    w_res_valid = 1'b0;
`ifdef M1AUTH_KS_STREAM_EN
    w_ks_valid  = 1'b0;
    w_streaming = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        c1_load_key = 1'b1;
        w_next      = S_INIT;
      end
      S_INIT: begin
        c1_start  = 1'b1;
        c1_ser_in = r_uidnt[r_cnt[4:0]];
        if (w_last) w_next = S_NR;
      end
      S_NR: begin
        c1_start  = 1'b1;
        c1_ser_in = r_nr[r_cnt[4:0]];
        if (w_last) w_next = S_AR;
      end
      S_AR: begin
        c1_start = 1'b1;
        if (w_last) w_next = S_FLUSH;
      end
      S_FLUSH: w_next = S_DONE;
      S_DONE: begin
        w_res_valid = 1'b1;
`ifdef M1AUTH_KS_STREAM_EN
        if (res_ready) w_next = S_STREAM;
`else
        if (res_ready) w_next = S_IDLE;
`endif
      end
`ifdef M1AUTH_KS_STREAM_EN
      S_STREAM: begin
        w_streaming = 1'b1;
        c1_start    = 1'b1;
        if (r_cnt == 7'd7) w_next = S_KS_FLUSH;
      end
      S_KS_FLUSH: begin
        w_streaming = 1'b1;
        w_next      = S_KS_OUT;
      end
      S_KS_OUT: begin
        w_streaming = 1'b1;
        w_ks_valid  = 1'b1;
        if (ks_ready) w_next = S_STREAM;
      end
`endif
      default: w_next = S_IDLE;
    endcase
`ifdef M1AUTH_KS_STREAM_EN
    if (w_streaming && stream_stop) w_next = S_IDLE;
`endif
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  assign c1_key     = r_key;
  assign busy       = (r_state != S_IDLE);
  assign res_valid  = w_res_valid;
  assign res_enc_nr = w_res_valid ? (r_ks_nr ^ r_nr) : '0;
  assign res_ks_ar  = w_res_valid ? r_ks_ar : '0;
`ifdef M1AUTH_KS_STREAM_EN
  assign ks_valid   = w_ks_valid;
  assign ks_byte    = w_ks_valid ? r_ks_byte : '0;
`endif

endmodule

// File: tb/tb_m1auth_seq.sv
// Testbench for m1auth_seq: a behavioural Crypto1 core closes the loop on
// c1_tx, and a software Crypto1 model fills a scoreboard of expected results.
module tb_m1auth_seq;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [47:0] cmd_key = '0;
  logic [31:0] cmd_uidnt = '0;
  logic [31:0] cmd_nr = '0;
  logic        abort = 1'b0;
  logic [47:0] c1_key;
  logic        c1_load_key, c1_start, c1_ser_in;
  logic        c1_tx;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_enc_nr, res_ks_ar;
  logic        busy;
`ifdef M1AUTH_KS_STREAM_EN
  logic        ks_valid;
  logic        ks_ready = 1'b0;
  logic [7:0]  ks_byte;
  logic        stream_stop = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 sysclk = ~sysclk;

  m1auth_seq dut (
    .sysclk(sysclk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_uidnt(cmd_uidnt), .cmd_nr(cmd_nr),
    .abort(abort),
    .c1_key(c1_key), .c1_load_key(c1_load_key), .c1_start(c1_start),
    .c1_ser_in(c1_ser_in), .c1_tx(c1_tx),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_enc_nr(res_enc_nr), .res_ks_ar(res_ks_ar),
    .busy(busy)
`ifdef M1AUTH_KS_STREAM_EN
    , .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_byte(ks_byte),
    .stream_stop(stream_stop)
`endif
  );

  // Crypto1 building blocks
  function automatic logic fa(logic a, logic b, logic c, logic d);
    return ((a | b) ^ (a & d)) ^ (c & ((a ^ b) | d));
  endfunction
  function automatic logic fb(logic a, logic b, logic c, logic d);
    return ((a & b) | c) ^ ((a ^ b) & (c | d));
  endfunction
  function automatic logic fc(logic a, logic b, logic c, logic d, logic e);
    return (a | ((b | e) & (d ^ e))) ^ ((a ^ (b & d)) & ((c ^ d) | (b & e)));
  endfunction
  function automatic logic filt(logic [47:0] s);
    return fc(fa(s[9], s[11], s[13], s[15]), fb(s[17], s[19], s[21], s[23]),
              fb(s[25], s[27], s[29], s[31]), fa(s[33], s[35], s[37], s[39]),
              fb(s[41], s[43], s[45], s[47]));
  endfunction
  function automatic logic [47:0] lstep(logic [47:0] s, logic in_bit);
    logic f;
    f = s[0] ^ s[5] ^ s[9] ^ s[10] ^ s[12] ^ s[14] ^ s[15] ^ s[17] ^ s[19] ^
        s[24] ^ s[25] ^ s[27] ^ s[29] ^ s[35] ^ s[39] ^ s[41] ^ s[42] ^ s[43];
    return {f ^ in_bit, s[47:1]};
  endfunction

  // Behavioural cipher core: tx is the registered keystream bit of a start pulse.
  logic [47:0] core_st = '0;
  logic        core_tx = 1'b0;
  assign c1_tx = core_tx;
  always @(posedge sysclk) begin
    if (c1_load_key) core_st <= c1_key;
    else if (c1_start) begin
      core_tx <= filt(core_st);
      core_st <= lstep(core_st, c1_ser_in);
    end
  end

  typedef struct {
    logic [31:0] enc_nr;
    logic [31:0] ks_ar;
    logic [31:0] ks_more;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;

  function automatic exp_t model(logic [47:0] key, logic [31:0] uidnt, logic [31:0] nr);
    exp_t e;
    logic [47:0] s;
    s = key;
    for (int i = 0; i < 32; i++) s = lstep(s, uidnt[i]);
    for (int i = 0; i < 32; i++) begin
      e.enc_nr[i] = nr[i] ^ filt(s);
      s = lstep(s, nr[i]);
    end
    for (int i = 0; i < 32; i++) begin
      e.ks_ar[i] = filt(s);
      s = lstep(s, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      e.ks_more[i] = filt(s);
      s = lstep(s, 1'b0);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // {load_key, start, ser_in, busy, cmd_ready, res_valid}
  function automatic logic [63:0] ctl();
    return 64'({c1_load_key, c1_start, c1_ser_in, busy, cmd_ready, res_valid});
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " ctl"}, ctl(), 64'b000010);
    check({tag, " res"}, {res_enc_nr, res_ks_ar}, 64'h0);
  endtask

  // Runs one command from cycle 0. abort_at / rst_at (>0) interrupt it at
  // that cycle; otherwise it stops in DONE at cycle 99 with results checked.
  task automatic run_cmd(input logic [47:0] key, input logic [31:0] uidnt,
                         input logic [31:0] nr, input int abort_at, input int rst_at);
    logic [63:0] exp_ctl;
    check("cmd_ready@0", 64'(cmd_ready), 64'h1);
    if (abort_at < 0 && rst_at < 0) sb_q.push_back(model(key, uidnt, nr));
    cmd_valid = 1'b1; cmd_key = key; cmd_uidnt = uidnt; cmd_nr = nr;
    tick();
    // Later changes on the command inputs must be ignored.
    cmd_valid = 1'b0; cmd_key = ~key; cmd_uidnt = ~uidnt; cmd_nr = ~nr;
    for (int cyc = 1; cyc <= 98; cyc++) begin
      if (cyc == 1)       exp_ctl = 64'b100100;
      else if (cyc <= 33) exp_ctl = {58'h0, 2'b01, uidnt[cyc-2], 3'b100};
      else if (cyc <= 65) exp_ctl = {58'h0, 2'b01, nr[cyc-34], 3'b100};
      else if (cyc <= 97) exp_ctl = 64'b010100;
      else                exp_ctl = 64'b000100;
      check($sformatf("ctl@%0d", cyc), ctl(), exp_ctl);
      if (cyc == 1) check("c1_key", 64'(c1_key), 64'(key));
      if (cyc == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle($sformatf("abort@%0d", cyc + 1));
        for (int k = 0; k < 5; k++) begin
          tick();
          check("post_abort res_valid", 64'(res_valid), 64'h0);
        end
        return;
      end
      if (cyc == rst_at) begin
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        check("async_reset c1_key", 64'(c1_key), 64'h0);
        tick();
        reset = 1'b0;
        tick();
        check_idle("after_reset");
        return;
      end
      tick();
    end
    check("res_valid@99", ctl(), 64'b000101);
    if (sb_q.size() == 0) begin
      check("scoreboard empty", 64'h1, 64'h0);
    end else begin
      cur = sb_q.pop_front();
      check("res_enc_nr", 64'(res_enc_nr), 64'(cur.enc_nr));
      check("res_ks_ar", 64'(res_ks_ar), 64'(cur.ks_ar));
    end
  endtask

  // Holds the result for 'hold' cycles, then accepts it. do_stream pulls four
  // keystream bytes when the stream feature is built in.
  task automatic accept_result(input int hold, input bit do_stream);
    for (int k = 0; k < hold; k++) begin
      tick();
      check($sformatf("hold ctl+%0d", k + 1), ctl(), 64'b000101);
      check($sformatf("hold res+%0d", k + 1), {res_enc_nr, res_ks_ar},
            {cur.enc_nr, cur.ks_ar});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`ifdef M1AUTH_KS_STREAM_EN
    check("stream entry ctl", ctl(), 64'b010100);
    if (do_stream) begin
      ks_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
        for (int w = 0; w < 20 && !ks_valid; w++) tick();
        check($sformatf("ks_byte%0d", b), 64'(ks_byte), 64'(cur.ks_more[8*b +: 8]));
        tick();
      end
      ks_ready = 1'b0;
    end
    stream_stop = 1'b1;
    tick();
    stream_stop = 1'b0;
    check_idle("stream_stop");
`else
    if (do_stream) check_idle("accept");
    else check_idle("accept");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #1;
    check_idle("reset");
    check("reset c1_key", 64'(c1_key), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // abort while idle has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_in_idle");

    // Test 1: all-ones key, zero nonces; immediate accept
    run_cmd(48'hFFFFFFFFFFFF, 32'h0, 32'h0, -1, -1);
    accept_result(0, 1'b0);

    // Tests 2/3/6: directed vector, result held 20 cycles
    run_cmd(48'hA0A1A2A3A4A5, 32'h12345678, 32'hDEADBEEF, -1, -1);
    accept_result(20, 1'b1);

    // Test 4: abort in NR phase, then repeat of the directed vector
    run_cmd(48'hA0A1A2A3A4A5, 32'h12345678, 32'hDEADBEEF, 50, -1);
    run_cmd(48'hA0A1A2A3A4A5, 32'h12345678, 32'hDEADBEEF, -1, -1);
    accept_result(0, 1'b0);

    // Test 5: reset in the AR phase, then a fresh command
    run_cmd(48'h0123456789AB, 32'hCAFEF00D, 32'h13579BDF, -1, 70);
    run_cmd(48'h0123456789AB, 32'hCAFEF00D, 32'h13579BDF, -1, -1);

    // abort together with res_ready in DONE ends in IDLE
    abort = 1'b1;
    res_ready = 1'b1;
    tick();
    abort = 1'b0;
    res_ready = 1'b0;
    check_idle("abort_with_res_ready");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
